datapath_rca_serial: RTL and testbench
======================================

Name: datapath_rca_serial

Overview:
- Parametrised, multi-cycle digit-serial ripple-carry adder/subtractor.
- Captures two WIDTH-bit operands on a load strobe and processes DIGIT bits per clock through a DIGIT-bit ripple-carry slice. The carry is registered between digits.
- Presents a registered WIDTH+1-bit result with a one-cycle done pulse.
- Successor to the fixed 4-bit combinational adder datapath: trades latency for area and adds a subtract mode and a handshake.

Parameters:
- WIDTH, 8, operand width in bits; must be an integer multiple of DIGIT.
- DIGIT, 2, bits processed per clock; 1 <= DIGIT <= WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- load  input  1  start strobe; sampled only when busy=0
- a  input  WIDTH  operand A, captured on accepted load
- b  input  WIDTH  operand B, captured on accepted load
- Cin  input  1  carry-in for add mode; ignored when sub=1
- sub  input  1  mode captured on accepted load; 0 = a+b+Cin, 1 = a-b (a + ~b + 1)
- Q  output  WIDTH+1  result; Q[WIDTH] = carry-out (in sub mode 1 = no borrow)
- busy  output  1  high while an operation is in progress
- done  output  1  one-cycle pulse when Q is updated

Behaviour:
- Reset (rst_n=0 at a rising edge): state=IDLE, Q=0, busy=0, done=0, digit counter=0, carry register=0. Reset overrides everything, including an operation mid-flight, which is abandoned; Q is not updated from it.
- N = WIDTH/DIGIT. FSM has two states, IDLE and RUN.
- IDLE, load=1 at edge t0:
  - Latch a, b, sub.
  - Carry register <= (sub ? 1 : Cin).
  - Counter <= 0; state <= RUN; busy=1 from t0.
- RUN, each edge:
  - Digit k (bits k*DIGIT .. k*DIGIT+DIGIT-1) of a and (sub ? ~b : b) is added with the carry register.
  - The DIGIT sum bits are written into an internal result shift/accumulate register; the carry register <= slice carry-out; counter++.
  - On the edge processing digit N-1:
    - Q <= {final carry, full sum}, done <= 1, busy <= 0, state <= IDLE.
    - done therefore asserts exactly N cycles after the load edge (edge t0+N).
- done is high for exactly one cycle; it is 0 otherwise.
- Q holds its last value between operations and is never partially updated.
- load while busy=1 is ignored; no queuing.
- load in the cycle done=1 is accepted (state is already IDLE), giving back-to-back throughput of one result per N cycles.
- Arithmetic is modulo 2^(WIDTH+1) on Q:
  - Add: Q = a + b + Cin.
  - Sub: Q = a + (~b & mask) + 1; Q[WIDTH]=1 iff a >= b (unsigned).
- DIGIT = WIDTH degenerates to N=1: done one cycle after load.

Optional Feature:
- Macro DATAPATH_RCA_OVF_EN.
- Defined:
  - Adds output port ovf (1 bit), updated with Q and reset to 0.
  - ovf = signed two's-complement overflow = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1 of the final digit.
- Undefined: port ovf and its logic are absent; all other behaviour is identical.

Test Plan:
1. Reset mid-operation: WIDTH=8, DIGIT=2; load a=0x12, b=0x34; assert rst_n=0 after 2 cycles -> Q=0x000, busy=0, done=0; no done pulse afterwards.
2. Add with carry-out: a=0xFF, b=0x01, Cin=0, sub=0 -> done at load edge+4, Q=0x100; busy high for 4 cycles.
3. Add with Cin: a=0x0F, b=0xF0, Cin=1 -> Q=0x100. Load re-asserted while busy -> ignored, Q unchanged and a single done pulse.
4. Subtract: a=0x05, b=0x03, sub=1 -> Q=0x102. Back-to-back load on the done cycle with a=0x03, b=0x05 -> Q=0x0FE, done 4 cycles later.
5. Parameter sweep (DIGIT=1, 4, 8 with WIDTH=8), random operands against a reference model -> Q matches and done latency equals 8, 2 and 1 cycles respectively.
6. With DATAPATH_RCA_OVF_EN: a=0x7F, b=0x01, add -> Q=0x080, ovf=1; a=0x80, b=0x01, sub -> Q=0x17F, ovf=1; a=0x10, b=0x01 add -> ovf=0.

Source files
------------

// File: rtl/datapath_rca_serial.sv
// Digit-serial ripple-carry adder/subtractor: DIGIT bits per clock, carry registered between digits.
// Optional signed-overflow output enabled by DATAPATH_RCA_OVF_EN.
module datapath_rca_serial #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             Cin,
  input  logic             sub,
  output logic [WIDTH:0]   Q,
  output logic             busy,
`ifdef DATAPATH_RCA_OVF_EN
  output logic             ovf,
`endif
  output logic             done
);
  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] bx_q, bx_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]   q_q, q_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
`ifdef DATAPATH_RCA_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  logic [DIGIT-1:0] dig_a, dig_b, dig_s;
  logic [DIGIT:0]   c;
  logic             last;

  // Operand B is stored pre-inverted in subtract mode, so the slice only ever adds.
  assign dig_a = a_q[int'(cnt_q)*DIGIT +: DIGIT];
  assign dig_b = bx_q[int'(cnt_q)*DIGIT +: DIGIT];
  assign c[0]  = carry_q;
  assign last  = (cnt_q == CW'(N-1));

  for (genvar g = 0; g < DIGIT; g++) begin : g_fa
    assign dig_s[g] = dig_a[g] ^ dig_b[g] ^ c[g];
    assign c[g+1]   = (dig_a[g] & dig_b[g]) | (c[g] & (dig_a[g] ^ dig_b[g]));
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    bx_d    = bx_q;
    acc_d   = acc_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
`ifdef DATAPATH_RCA_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (load) begin
          a_d     = a;
          bx_d    = sub ? ~b : b;
          carry_d = sub ? 1'b1 : Cin;
          cnt_d   = '0;
          acc_d   = '0;
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d[int'(cnt_q)*DIGIT +: DIGIT] = dig_s;
        carry_d = c[DIGIT];
        cnt_d   = cnt_q + CW'(1);
        if (last) begin
          // Q only changes here, so it never shows a partial sum.
          q_d     = {c[DIGIT], acc_d};
          done_d  = 1'b1;
          busy_d  = 1'b0;
          cnt_d   = '0;
          state_d = IDLE;
`ifdef DATAPATH_RCA_OVF_EN
          ovf_d   = c[DIGIT-1] ^ c[DIGIT];
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      bx_q    <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      q_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef DATAPATH_RCA_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      bx_q    <= bx_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef DATAPATH_RCA_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign Q    = q_q;
  assign busy = busy_q;
  assign done = done_q;
`ifdef DATAPATH_RCA_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_datapath_rca_serial.sv
// Bench for datapath_rca_serial: four instances (DIGIT=2,1,4,8 at WIDTH=8) against an arithmetic model.
// Build with DATAPATH_RCA_OVF_EN defined to also check the overflow output.
module tb_datapath_rca_serial;
  localparam int NI = 4;
  localparam int LAT [NI] = '{4, 8, 2, 1};

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NI-1:0] ld;
  logic [7:0]    a_i, b_i;
  logic          cin_i, sub_i;
  logic [8:0]    q_o    [NI];
  logic          busy_o [NI];
  logic          done_o [NI];
  logic          ovf_o  [NI];

  int n_chk  = 0;
  int n_fail = 0;
  int dcount0 = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int DG = (g == 0) ? 2 : (g == 1) ? 1 : (g == 2) ? 4 : 8;
    datapath_rca_serial #(.WIDTH(8), .DIGIT(DG)) u_dut (
      .clk  (clk),
      .rst_n(rst_n),
      .load (ld[g]),
      .a    (a_i),
      .b    (b_i),
      .Cin  (cin_i),
      .sub  (sub_i),
      .Q    (q_o[g]),
      .busy (busy_o[g]),
`ifdef DATAPATH_RCA_OVF_EN
      .ovf  (ovf_o[g]),
`endif
      .done (done_o[g])
    );
`ifndef DATAPATH_RCA_OVF_EN
    assign ovf_o[g] = 1'b0;
`endif
  end

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  // Behavioural model: result from plain arithmetic, appearing LAT cycles after an accepted load.
  logic       mvalid = 1'b0;
  logic       m_busy [NI];
  logic       m_done [NI];
  logic [8:0] m_q    [NI];
  logic       m_ovf  [NI];
  logic [8:0] m_pq   [NI];
  logic       m_pov  [NI];
  int         m_cnt  [NI];

  always @(posedge clk) begin
    logic [7:0] bx;
    logic [9:0] r;
    if (!rst_n) begin
      mvalid = 1'b1;
      for (int i = 0; i < NI; i++) begin
        m_busy[i] = 1'b0; m_done[i] = 1'b0; m_q[i] = '0; m_ovf[i] = 1'b0; m_cnt[i] = 0;
      end
    end else begin
      for (int i = 0; i < NI; i++) begin
        m_done[i] = 1'b0;
        if (m_busy[i]) begin
          m_cnt[i]--;
          if (m_cnt[i] == 0) begin
            m_busy[i] = 1'b0; m_done[i] = 1'b1; m_q[i] = m_pq[i]; m_ovf[i] = m_pov[i];
          end
        end else if (ld[i]) begin
          bx = sub_i ? ~b_i : b_i;
          r  = {2'b0, a_i} + {2'b0, bx} + {9'b0, (sub_i ? 1'b1 : cin_i)};
          m_pq[i]   = r[8:0];
          m_pov[i]  = (a_i[7] == bx[7]) && (r[7] != a_i[7]);
          m_cnt[i]  = LAT[i];
          m_busy[i] = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (done_o[0] === 1'b1) dcount0++;
    if (mvalid) begin
      for (int i = 0; i < NI; i++) begin
        check($sformatf("q%0d", i),    32'(q_o[i]),    32'(m_q[i]));
        check($sformatf("busy%0d", i), 32'(busy_o[i]), 32'(m_busy[i]));
        check($sformatf("done%0d", i), 32'(done_o[i]), 32'(m_done[i]));
`ifdef DATAPATH_RCA_OVF_EN
        check($sformatf("ovf%0d", i),  32'(ovf_o[i]),  32'(m_ovf[i]));
`endif
      end
    end
  end

  // Called right after a negedge; pulses load across exactly one rising edge.
  task automatic launch(input logic [NI-1:0] m, input logic [7:0] aa, input logic [7:0] bb,
                        input logic c, input logic s);
    a_i = aa; b_i = bb; cin_i = c; sub_i = s; ld = m;
    @(negedge clk);
    ld = '0;
  endtask

  // Waits for done on instance i; k counts negedges after the load edge.
  task automatic wait_done(input int i, input int k0, input int lat_exp,
                           input logic [8:0] q_exp, input string nm);
    int  k = k0;
    bit  seen = 0;
    while (k < 20 && !seen) begin
      @(negedge clk);
      k++;
      if (done_o[i] === 1'b1) seen = 1;
    end
    check({nm, "_lat"}, 32'(k), 32'(lat_exp));
    if (seen) check({nm, "_q"}, 32'(q_o[i]), 32'(q_exp));
  endtask

  task automatic wait_multi(input string nm);
    int lat [NI];
    for (int i = 0; i < NI; i++) lat[i] = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      for (int i = 1; i < NI; i++) if (done_o[i] === 1'b1 && lat[i] == 0) lat[i] = k;
    end
    for (int i = 1; i < NI; i++) check($sformatf("%s_lat%0d", nm, i), 32'(lat[i]), 32'(LAT[i]));
  endtask

  initial begin
    int snap;
    rst_n = 1'b0; ld = '0; a_i = '0; b_i = '0; cin_i = 1'b0; sub_i = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_q", 32'(q_o[0]), 32'h0);
    check("rst_busy", 32'(busy_o[0]), 32'h0);
    check("rst_done", 32'(done_o[0]), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset in the middle of an operation abandons it.
    launch(4'b0001, 8'h12, 8'h34, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_q", 32'(q_o[0]), 32'h0);
    check("midrst_busy", 32'(busy_o[0]), 32'h0);
    check("midrst_done", 32'(done_o[0]), 32'h0);
    rst_n = 1'b1;
    snap = dcount0;
    repeat (8) @(negedge clk);
    check("midrst_nodone", 32'(dcount0 - snap), 32'h0);

    // Add with carry-out.
    launch(4'b0001, 8'hFF, 8'h01, 1'b0, 1'b0);
    check("add_busy", 32'(busy_o[0]), 32'h1);
    wait_done(0, 0, 4, 9'h100, "add_co");
    check("add_busy_end", 32'(busy_o[0]), 32'h0);

    // Add with Cin; load re-asserted while busy must be ignored.
    @(negedge clk);
    snap = dcount0;
    launch(4'b0001, 8'h0F, 8'hF0, 1'b1, 1'b0);
    a_i = 8'h01; b_i = 8'h01; ld = 4'b0001;
    @(negedge clk);
    ld = '0;
    wait_done(0, 1, 4, 9'h100, "add_cin");
    repeat (6) @(negedge clk);
    check("busy_load_single_done", 32'(dcount0 - snap), 32'h1);
    check("busy_load_q_hold", 32'(q_o[0]), 32'h100);

    // Subtract, then back-to-back load on the done cycle.
    launch(4'b0001, 8'h05, 8'h03, 1'b0, 1'b1);
    wait_done(0, 0, 4, 9'h102, "sub_pos");
    launch(4'b0001, 8'h03, 8'h05, 1'b0, 1'b1);
    wait_done(0, 0, 4, 9'h0FE, "sub_neg");

    // Parameter sweep: DIGIT=1,4,8 in parallel; values checked by the per-cycle model compare.
    launch(4'b1110, 8'h00, 8'h00, 1'b0, 1'b1);
    wait_multi("sw_zero");
    check("sw_zero_q8", 32'(q_o[3]), 32'h100);
    launch(4'b1110, 8'hFF, 8'hFF, 1'b1, 1'b0);
    wait_multi("sw_max");
    check("sw_max_q1", 32'(q_o[1]), 32'h1FF);
    for (int t = 0; t < 6; t++) begin
      launch(4'b1110, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
      wait_multi($sformatf("sw_rnd%0d", t));
    end

`ifdef DATAPATH_RCA_OVF_EN
    launch(4'b0001, 8'h7F, 8'h01, 1'b0, 1'b0);
    wait_done(0, 0, 4, 9'h080, "ovf_add");
    check("ovf_add_flag", 32'(ovf_o[0]), 32'h1);
    launch(4'b0001, 8'h80, 8'h01, 1'b0, 1'b1);
    wait_done(0, 0, 4, 9'h17F, "ovf_sub");
    check("ovf_sub_flag", 32'(ovf_o[0]), 32'h1);
    launch(4'b0001, 8'h10, 8'h01, 1'b0, 1'b0);
    wait_done(0, 0, 4, 9'h011, "ovf_none");
    check("ovf_none_flag", 32'(ovf_o[0]), 32'h0);
`endif

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
